x_cfglut_n: RTL and testbench

- Parametrised, runtime-reconfigurable K-input lookup table: the next generation of our fixed-INIT LUT primitives.
- Truth table powers up from INIT and can be reloaded serially at clock rate: CE/CDI in, CDO out for daisy-chaining.
- Provides a combinational output, an optionally registered output, and a load-complete pulse from an internal frame counter.
- Used as a reconfigurable logic cell in simulation netlists and for reconfiguration test benches.

---
 rtl/x_lut_pkg.sv | 21 ++
 rtl/x_lut_shreg.sv | 42 ++++
 rtl/x_cfglut_n.sv | 103 ++++++++++
 tb/tb_x_cfglut_n.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_lut_pkg.sv
// Shared definitions for the reconfigurable LUT cells: load FSM states,
// table depth helper and the legal address-width range.
package x_lut_pkg;

    localparam int K_MIN = 2;
    localparam int K_MAX = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } cfg_state_e;

    function automatic int tbl_depth(input int k);
        return 1 << k;
    endfunction

    function automatic bit k_legal(input int k);
        return (k >= K_MIN) && (k <= K_MAX);
    endfunction

endpackage

// File: rtl/x_lut_shreg.sv
// Truth-table storage: a 2^K-bit serial shift register with a parallel read mux.
// New frames enter at bit 0 and leave from the MSB, so chained cells load MSB first.
module x_lut_shreg
    import x_lut_pkg::*;
#(
    parameter int                         K    = 8,
    parameter logic [tbl_depth(K)-1:0]    INIT = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         ce_i,
    input  logic         cdi_i,
    input  logic [K-1:0] adr_i,
    output logic         o_o,
    output logic         cdo_o
);

    localparam int DEPTH = tbl_depth(K);

    logic [DEPTH-1:0] tbl_q;
    logic [DEPTH-1:0] tbl_d;

    always_comb begin
        tbl_d = tbl_q;
        if (ce_i) begin
            tbl_d = {tbl_q[DEPTH-2:0], cdi_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tbl_q <= INIT;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Reads are intentionally unmasked during a load and see the partial frame.
    assign o_o   = tbl_q[adr_i];
    assign cdo_o = tbl_q[DEPTH-1];

endmodule

// File: rtl/x_cfglut_n.sv
// Runtime-reconfigurable K-input LUT: serial truth-table reload with a frame
// counter that flags partial loads (CFG_BUSY) and completed frames (CFG_DONE).
module x_cfglut_n
    import x_lut_pkg::*;
#(
    parameter int                         K       = 8,
    parameter logic [tbl_depth(K)-1:0]    INIT    = '0,
    parameter bit                         REG_OUT = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [K-1:0] ADR,
    input  logic         CE,
    input  logic         CDI,
    output logic         O,
    output logic         OQ,
    output logic         CDO,
    output logic         CFG_BUSY,
    output logic         CFG_DONE
);

    localparam int         DEPTH    = tbl_depth(K);
    localparam logic [K:0] LAST_CNT = (K+1)'(DEPTH - 1);
    localparam logic [K:0] ONE_CNT  = (K+1)'(1);

    generate
        if (!k_legal(K)) begin : g_k_range
            $error("x_cfglut_n: K=%0d outside legal range %0d..%0d", K, K_MIN, K_MAX);
        end
    endgenerate

    logic       o_w;
    cfg_state_e state_q;
    logic [K:0] cnt_q;
    logic       done_q;

    x_lut_shreg #(
        .K    (K),
        .INIT (INIT)
    ) u_shreg (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .ce_i    (CE),
        .cdi_i   (CDI),
        .adr_i   (ADR),
        .o_o     (o_w),
        .cdo_o   (CDO)
    );

    // The frame counter only advances on CE, so a paused load resumes in place.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (CE) begin
                case (state_q)
                    IDLE: begin
                        state_q <= LOAD;
                        cnt_q   <= ONE_CNT;
                    end
                    LOAD: begin
                        if (cnt_q == LAST_CNT) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + ONE_CNT;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    generate
        if (REG_OUT) begin : g_oq_reg
            logic oq_q;
            // Samples the pre-shift table, matching what O showed before the edge.
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    oq_q <= INIT[0];
                end else begin
                    oq_q <= o_w;
                end
            end
            assign OQ = oq_q;
        end else begin : g_oq_comb
            assign OQ = o_w;
        end
    endgenerate

    assign O        = o_w;
    assign CFG_BUSY = (state_q == LOAD);
    assign CFG_DONE = done_q;

endmodule

// File: tb/tb_x_cfglut_n.sv
// Bench for x_cfglut_n: three instances (K=3 registered, K=4 registered,
// K=8 combinational OQ) driven one scenario task at a time.
module tb_x_cfglut_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic exp_oq_q[$];
    logic cdi_hist_q[$];

    logic       k3_rst_n, k3_ce, k3_cdi;
    logic [2:0] k3_adr;
    logic       k3_o, k3_oq, k3_cdo, k3_busy, k3_done;

    logic       k4_rst_n, k4_ce, k4_cdi;
    logic [3:0] k4_adr;
    logic       k4_o, k4_oq, k4_cdo, k4_busy, k4_done;

    logic       k8_rst_n, k8_ce, k8_cdi;
    logic [7:0] k8_adr;
    logic       k8_o, k8_oq, k8_cdo, k8_busy, k8_done;

    logic [7:0]   m3;
    logic [15:0]  m4;
    logic [255:0] m8;

    x_cfglut_n #(.K(3), .INIT(8'hCA), .REG_OUT(1'b1)) u_k3 (
        .CLK(clk), .RST_N(k3_rst_n), .ADR(k3_adr), .CE(k3_ce), .CDI(k3_cdi),
        .O(k3_o), .OQ(k3_oq), .CDO(k3_cdo), .CFG_BUSY(k3_busy), .CFG_DONE(k3_done)
    );

    x_cfglut_n #(.K(4), .INIT(16'h0000), .REG_OUT(1'b1)) u_k4 (
        .CLK(clk), .RST_N(k4_rst_n), .ADR(k4_adr), .CE(k4_ce), .CDI(k4_cdi),
        .O(k4_o), .OQ(k4_oq), .CDO(k4_cdo), .CFG_BUSY(k4_busy), .CFG_DONE(k4_done)
    );

    x_cfglut_n #(.K(8), .INIT({1'b1, 255'b0}), .REG_OUT(1'b0)) u_k8 (
        .CLK(clk), .RST_N(k8_rst_n), .ADR(k8_adr), .CE(k8_ce), .CDI(k8_cdi),
        .O(k8_o), .OQ(k8_oq), .CDO(k8_cdo), .CFG_BUSY(k8_busy), .CFG_DONE(k8_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_o;
        logic       e;
        exp_o = 8'hCA;
        k3_rst_n = 1'b0; k3_ce = 1'b0; k3_cdi = 1'b0; k3_adr = '0;
        k4_rst_n = 1'b0; k4_ce = 1'b0; k4_cdi = 1'b0; k4_adr = '0;
        k8_rst_n = 1'b0; k8_ce = 1'b0; k8_cdi = 1'b0; k8_adr = '0;
        tick();
        k3_rst_n = 1'b1; k4_rst_n = 1'b1; k8_rst_n = 1'b1;
        m3 = 8'hCA; m4 = '0; m8 = {1'b1, 255'b0};
        #1;
        n_checks++;
        if (k3_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", k3_busy); end
        n_checks++;
        if (k3_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", k3_done); end
        n_checks++;
        if (k3_oq !== 1'b0) begin n_err++; $display("FAIL reset_oq got=%b exp=0", k3_oq); end
        n_checks++;
        if (k4_busy !== 1'b0 || k8_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy_k4k8 got=%b%b exp=00", k4_busy, k8_busy);
        end
        for (int a = 0; a < 8; a++) begin
            k3_adr = 3'(a);
            #1;
            n_checks++;
            if (k3_o !== exp_o[a]) begin
                n_err++; $display("FAIL reset_o adr=%0d got=%b exp=%b", a, k3_o, exp_o[a]);
            end
            exp_oq_q.push_back(exp_o[a]);
            tick();
            e = exp_oq_q.pop_front();
            n_checks++;
            if (k3_oq !== e) begin
                n_err++; $display("FAIL reset_oq adr=%0d got=%b exp=%b", a, k3_oq, e);
            end
        end
    endtask

    task automatic test_full_reload();
        logic [7:0] frame;
        logic [7:0] exp_cdo;
        logic       e;
        frame   = 8'h5A;
        exp_cdo = 8'hCA;
        for (int i = 0; i < 8; i++) begin
            k3_ce  = 1'b1;
            k3_cdi = frame[7-i];
            k3_adr = 3'(i);
            #1;
            n_checks++;
            if (k3_cdo !== exp_cdo[7-i]) begin
                n_err++; $display("FAIL reload_cdo step=%0d got=%b exp=%b", i, k3_cdo, exp_cdo[7-i]);
            end
            n_checks++;
            if (k3_busy !== (i != 0)) begin
                n_err++; $display("FAIL reload_busy step=%0d got=%b exp=%b", i, k3_busy, (i != 0));
            end
            n_checks++;
            if (k3_done !== 1'b0) begin
                n_err++; $display("FAIL reload_done_early step=%0d got=%b exp=0", i, k3_done);
            end
            exp_oq_q.push_back(m3[i]);
            tick();
            m3 = {m3[6:0], frame[7-i]};
            e = exp_oq_q.pop_front();
            n_checks++;
            if (k3_oq !== e) begin
                n_err++; $display("FAIL reload_oq step=%0d got=%b exp=%b", i, k3_oq, e);
            end
        end
        k3_ce  = 1'b0;
        k3_adr = 3'd1;
        #1;
        n_checks++;
        if (k3_done !== 1'b1) begin n_err++; $display("FAIL reload_done got=%b exp=1", k3_done); end
        n_checks++;
        if (k3_busy !== 1'b0) begin n_err++; $display("FAIL reload_busy_end got=%b exp=0", k3_busy); end
        n_checks++;
        if (k3_o !== 1'b1) begin n_err++; $display("FAIL reload_o_adr1 got=%b exp=1", k3_o); end
        tick();
        n_checks++;
        if (k3_done !== 1'b0) begin n_err++; $display("FAIL reload_done_width got=%b exp=0", k3_done); end
        k3_adr = 3'd0;
        #1;
        n_checks++;
        if (k3_o !== 1'b0) begin n_err++; $display("FAIL reload_o_adr0 got=%b exp=0", k3_o); end
        for (int a = 0; a < 8; a++) begin
            k3_adr = 3'(a);
            #1;
            n_checks++;
            if (k3_o !== frame[a]) begin
                n_err++; $display("FAIL reload_table adr=%0d got=%b exp=%b", a, k3_o, frame[a]);
            end
        end
    endtask

    task automatic test_paused_load();
        logic [7:0] frame;
        int         j;
        frame = 8'(($urandom & 8'hFF));
        j = 0;
        tick();
        for (int s = 0; s < 13; s++) begin
            k3_ce = !(s >= 3 && s < 8);
            k3_cdi = k3_ce ? frame[7-j] : ~frame[7-j];
            #1;
            n_checks++;
            if (k3_busy !== (j != 0)) begin
                n_err++; $display("FAIL pause_busy step=%0d got=%b exp=%b", s, k3_busy, (j != 0));
            end
            n_checks++;
            if (k3_done !== 1'b0) begin
                n_err++; $display("FAIL pause_done_early step=%0d got=%b exp=0", s, k3_done);
            end
            if (k3_ce) begin
                n_checks++;
                if (k3_cdo !== m3[7]) begin
                    n_err++; $display("FAIL pause_cdo step=%0d got=%b exp=%b", s, k3_cdo, m3[7]);
                end
            end
            tick();
            if (k3_ce) begin
                m3 = {m3[6:0], frame[7-j]};
                j++;
            end
        end
        k3_ce = 1'b0;
        #1;
        n_checks++;
        if (k3_done !== 1'b1) begin n_err++; $display("FAIL pause_done got=%b exp=1", k3_done); end
        tick();
        n_checks++;
        if (k3_done !== 1'b0) begin n_err++; $display("FAIL pause_done_width got=%b exp=0", k3_done); end
        for (int a = 0; a < 8; a++) begin
            k3_adr = 3'(a);
            #1;
            n_checks++;
            if (k3_o !== frame[a]) begin
                n_err++; $display("FAIL pause_table adr=%0d got=%b exp=%b", a, k3_o, frame[a]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] init_tbl;
        logic [7:0] frame;
        init_tbl = 8'hCA;
        tick();
        for (int i = 0; i < 4; i++) begin
            k3_ce  = 1'b1;
            k3_cdi = 1'($urandom_range(0, 1));
            tick();
        end
        k3_rst_n = 1'b0;
        k3_ce    = 1'b1;
        k3_cdi   = 1'b1;
        tick();
        k3_rst_n = 1'b1;
        k3_ce    = 1'b0;
        m3 = init_tbl;
        #1;
        n_checks++;
        if (k3_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", k3_busy); end
        n_checks++;
        if (k3_done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", k3_done); end
        n_checks++;
        if (k3_oq !== init_tbl[0]) begin n_err++; $display("FAIL midrst_oq got=%b exp=%b", k3_oq, init_tbl[0]); end
        for (int a = 0; a < 8; a++) begin
            k3_adr = 3'(a);
            #1;
            n_checks++;
            if (k3_o !== init_tbl[a]) begin
                n_err++; $display("FAIL midrst_table adr=%0d got=%b exp=%b", a, k3_o, init_tbl[a]);
            end
        end
        tick();
        frame = 8'(($urandom & 8'hFF));
        for (int i = 0; i < 8; i++) begin
            k3_ce  = 1'b1;
            k3_cdi = frame[7-i];
            #1;
            n_checks++;
            if (k3_done !== 1'b0 || k3_busy !== (i != 0)) begin
                n_err++; $display("FAIL midrst_reload step=%0d got done=%b busy=%b exp done=0 busy=%b",
                                  i, k3_done, k3_busy, (i != 0));
            end
            tick();
        end
        k3_ce = 1'b0;
        #1;
        n_checks++;
        if (k3_done !== 1'b1) begin n_err++; $display("FAIL midrst_reload_done got=%b exp=1", k3_done); end
        for (int a = 0; a < 8; a++) begin
            k3_adr = 3'(a);
            #1;
            n_checks++;
            if (k3_o !== frame[a]) begin
                n_err++; $display("FAIL midrst_reload_table adr=%0d got=%b exp=%b", a, k3_o, frame[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic b;
        tick();
        for (int n = 1; n <= 48; n++) begin
            k4_ce  = 1'b1;
            b      = 1'($urandom_range(0, 1));
            k4_cdi = b;
            cdi_hist_q.push_back(b);
            #1;
            n_checks++;
            if (k4_cdo !== m4[15]) begin
                n_err++; $display("FAIL b2b_cdo cycle=%0d got=%b exp=%b", n, k4_cdo, m4[15]);
            end
            tick();
            m4 = {m4[14:0], b};
            n_checks++;
            if (k4_done !== ((n % 16) == 0) || k4_busy !== ((n % 16) != 0)) begin
                n_err++; $display("FAIL b2b_flags cycle=%0d got done=%b busy=%b exp done=%b busy=%b",
                                  n, k4_done, k4_busy, ((n % 16) == 0), ((n % 16) != 0));
            end
        end
        k4_ce = 1'b0;
        tick();
        n_checks++;
        if (k4_done !== 1'b0) begin n_err++; $display("FAIL b2b_done_after got=%b exp=0", k4_done); end
        while (cdi_hist_q.size() > 16) void'(cdi_hist_q.pop_front());
        for (int j = 0; j < 16; j++) begin
            k4_adr = 4'(15 - j);
            b = cdi_hist_q.pop_front();
            #1;
            n_checks++;
            if (k4_o !== b) begin
                n_err++; $display("FAIL b2b_table adr=%0d got=%b exp=%b", 15 - j, k4_o, b);
            end
        end
    endtask

    task automatic test_k8_comb_oq();
        logic [7:0] adrs [6];
        logic       e;
        adrs = '{8'h00, 8'h01, 8'h7F, 8'hFE, 8'hFF, 8'h00};
        adrs[5] = 8'($urandom_range(0, 254));
        for (int i = 0; i < 6; i++) begin
            k8_adr = adrs[i];
            #1;
            e = m8[k8_adr];
            exp_oq_q.push_back(e);
            n_checks++;
            if (k8_o !== (adrs[i] == 8'hFF)) begin
                n_err++; $display("FAIL k8_o adr=%0h got=%b exp=%b", adrs[i], k8_o, (adrs[i] == 8'hFF));
            end
            e = exp_oq_q.pop_front();
            n_checks++;
            if (k8_oq !== e) begin
                n_err++; $display("FAIL k8_oq adr=%0h got=%b exp=%b", adrs[i], k8_oq, e);
            end
            tick();
        end
        k8_ce  = 1'b1;
        k8_cdi = 1'b1;
        k8_adr = 8'hFF;
        #1;
        n_checks++;
        if (k8_cdo !== 1'b1) begin n_err++; $display("FAIL k8_cdo got=%b exp=1", k8_cdo); end
        tick();
        m8 = {m8[254:0], 1'b1};
        k8_ce = 1'b0;
        n_checks++;
        if (k8_o !== m8[255] || k8_oq !== m8[255]) begin
            n_err++; $display("FAIL k8_shift_ff got o=%b oq=%b exp=%b", k8_o, k8_oq, m8[255]);
        end
        k8_adr = 8'h00;
        #1;
        n_checks++;
        if (k8_o !== m8[0] || k8_oq !== m8[0]) begin
            n_err++; $display("FAIL k8_shift_00 got o=%b oq=%b exp=%b", k8_o, k8_oq, m8[0]);
        end
        n_checks++;
        if (k8_busy !== 1'b1 || k8_done !== 1'b0) begin
            n_err++; $display("FAIL k8_flags got busy=%b done=%b exp busy=1 done=0", k8_busy, k8_done);
        end
    endtask

    initial begin
        test_reset();
        test_full_reload();
        test_paused_load();
        test_reset_mid_frame();
        test_back_to_back();
        test_k8_comb_oq();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
